lfsr_seq: RTL and testbench

Seedable Fibonacci LFSR sequencer built from single-bit register cells. It is the stage directly downstream of the single-bit D flip-flop: it chains WIDTH such cells into a shift register with XOR feedback. It presents each state on a valid/ready output port, flags an illegal all-zero seed, and measures the sequence period after each load.

---
 rtl/lfsr_pkg.sv | 28 ++
 rtl/lfsr_cell.sv | 38 +++
 rtl/lfsr_seq.sv | 163 ++++++++++++++++
 tb/tb_lfsr_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_pkg
//  Description : Shared constants for the seedable Fibonacci LFSR sequencer.
//                Holds the sequencer state encoding, the default register
//                width and feedback mask, and a small helper for seed checks.
//  Revision    : 1.0  initial release
// ============================================================================
package lfsr_pkg;

  // Sequencer state encoding (explicit 2-bit width)
  localparam logic [1:0] S_IDLE = 2'd0;  // out of reset, no seed loaded yet
  localparam logic [1:0] S_RUN  = 2'd1;  // legal seed loaded, stepping allowed
  localparam logic [1:0] S_ZERO = 2'd2;  // all-zero seed loaded, locked up

  // Default geometry: x^4 + x^3 + 1, a maximal-length 4-bit polynomial.
  // The mask is kept 16 bits wide so any legal WIDTH (2..16) can slice it.
  localparam int          DEFAULT_WIDTH = 4;
  localparam logic [15:0] DEFAULT_TAPS  = 16'h0009;

  // An all-zero LFSR state is a fixed point of XOR feedback, so such a seed
  // can never produce a sequence and is treated as an error.
  function automatic logic seed_is_zero(input logic [15:0] value);
    return (value == 16'h0000);
  endfunction

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr_cell.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_cell
//  Description : One bit of the LFSR shift register. Synchronous active-low
//                reset, a load mux selecting the seed bit over the shift-in
//                bit, and an advance enable that otherwise holds the bit.
//  Ports       : clock     - system clock, rising edge
//                reset     - synchronous active-low reset
//                load      - capture seed_bit this cycle
//                seed_bit  - seed value for this bit position
//                shift_in  - value arriving from the previous stage / feedback
//                advance   - take shift_in this cycle (ignored under load)
//                q         - registered cell value
//  Revision    : 1.0  initial release
// ============================================================================
module lfsr_cell (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic seed_bit,
  input  logic shift_in,
  input  logic advance,
  output logic q
);

  // Priority: reset, then load, then advance; otherwise hold.
  always_ff @(posedge clock) begin
    if (!reset) begin
      q <= 1'b0;
    end else if (load) begin
      q <= seed_bit;
    end else if (advance) begin
      q <= shift_in;
    end
  end

endmodule : lfsr_cell
`default_nettype wire

// File: rtl/lfsr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_seq
//  Description : Seedable Fibonacci LFSR sequencer. Chains WIDTH lfsr_cell
//                instances into a shift register with XOR feedback, presents
//                each state on a valid/ready port, flags an all-zero seed and
//                measures the sequence period after each load.
//  Ports       : clock      - system clock, rising edge
//                reset      - synchronous active-low reset
//                load       - load seed this cycle (beats a simultaneous step)
//                seed       - seed value, sampled when load=1
//                enable     - gates out_valid; 0 freezes the sequence
//                out_ready  - consumer accepts q this cycle
//                out_valid  - q holds a valid state
//                q          - current LFSR state
//                serial_out - q[WIDTH-1]
//                wrap       - one-cycle pulse: state returned to the seed
//                period     - steps counted for the last completed cycle
//                error      - all-zero seed loaded
//  Revision    : 1.0  initial release
// ============================================================================
module lfsr_seq
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS[WIDTH-1:0]
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             enable,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             error
);

  // --------------------------------------------------------------------------
  // Internal signals
  // --------------------------------------------------------------------------
  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] cell_q;       // assembled outputs of the cell chain
  logic [WIDTH-1:0] q_next;       // state after one shift
  logic             fb;           // feedback bit entering cell 0
  logic             fire;         // handshake completes this cycle
  logic             advance;      // cells shift this cycle
  logic             seed_zero;
  logic [WIDTH-1:0] seed_reg;     // seed captured at load, for wrap detection
  logic [WIDTH-1:0] count;        // steps taken since load / last wrap
  logic [WIDTH-1:0] count_inc;

  // --------------------------------------------------------------------------
  // Feedback and shift
  // --------------------------------------------------------------------------
  assign fb        = ^(cell_q & TAPS);
  assign q_next    = {cell_q[WIDTH-2:0], fb};
  assign seed_zero = (seed == '0);

  assign fire      = out_valid & out_ready;
  // A load in the same cycle as a handshake discards that step.
  assign advance   = fire & ~load;

  // --------------------------------------------------------------------------
  // Register chain: cell 0 takes the feedback bit, every other cell takes
  // its lower neighbour, giving a left shift towards serial_out.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      logic shift_in;

      if (i == 0) begin : g_head
        assign shift_in = fb;
      end else begin : g_tail
        assign shift_in = cell_q[i-1];
      end

      lfsr_cell u_cell (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .seed_bit (seed[i]),
        .shift_in (shift_in),
        .advance  (advance),
        .q        (cell_q[i])
      );
    end
  endgenerate

  assign q          = cell_q;
  assign serial_out = cell_q[WIDTH-1];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic. Only a load moves the sequencer; an all-zero seed
  // parks it in ZERO, anything else starts RUN. RUN is never left by itself.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    if (load) begin
      state_next = seed_zero ? S_ZERO : S_RUN;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: output logic. The only combinational output path in the block.
  // --------------------------------------------------------------------------
  always_comb begin
    out_valid = 1'b0;
    if (state == S_RUN) begin
      out_valid = enable;
    end
  end

  // --------------------------------------------------------------------------
  // Step counter, period capture, wrap pulse and error flag.
  // count is the number of steps already taken in the current cycle, so the
  // step that lands back on the seed completes a cycle of count+1 steps.
  // --------------------------------------------------------------------------
  assign count_inc = count + 1'b1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count    <= '0;
      period   <= '0;
      wrap     <= 1'b0;
      error    <= 1'b0;
      seed_reg <= '0;
    end else if (load) begin
      count    <= '0;
      wrap     <= 1'b0;
      error    <= seed_zero;
      seed_reg <= seed;
    end else if (fire) begin
      if (q_next == seed_reg) begin
        wrap   <= 1'b1;
        period <= count_inc;
        count  <= '0;
      end else begin
        wrap   <= 1'b0;
        count  <= count_inc;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule : lfsr_seq
`default_nettype wire

// File: tb/tb_lfsr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_seq
//  Description : Self-checking bench for lfsr_seq (WIDTH=4, TAPS=4'b1001).
//                Directed scenarios plus randomized traffic, all compared
//                against a behavioural model of the sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lfsr_seq;

  localparam int         W    = 4;
  localparam logic [3:0] TAPS = 4'b1001;

  logic         clock = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] seed;
  logic         enable;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] q;
  logic         serial_out;
  logic         wrap;
  logic [W-1:0] period;
  logic         error;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model
  int  m_q, m_count, m_period, m_seed;
  bit  m_wrap, m_err, m_live;

  // Expected maximal-length sequence from seed 0001
  logic [3:0] seq [0:15] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                             4'b1110, 4'b1101, 4'b1010, 4'b0101,
                             4'b1011, 4'b0110, 4'b1100, 4'b1001,
                             4'b0010, 4'b0100, 4'b1000, 4'b0001};

  lfsr_seq #(.WIDTH(W), .TAPS(TAPS)) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .seed       (seed),
    .enable     (enable),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .q          (q),
    .serial_out (serial_out),
    .wrap       (wrap),
    .period     (period),
    .error      (error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Next state by arithmetic: shift left within 4 bits, new LSB is the
  // parity of the tapped bits.
  function automatic int model_next(input int s);
    int fbv;
    fbv = $countones(s & int'(TAPS)) % 2;
    return ((s * 2) % 16) + fbv;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven,
  // then compare every output just after the edge.
  task automatic step();
    bit f;
    int nq;
    f = m_live && enable && out_ready;
    if (!reset) begin
      m_q = 0; m_count = 0; m_period = 0; m_wrap = 0; m_err = 0; m_live = 0;
      m_seed = 0;
    end else if (load) begin
      m_q = int'(seed); m_count = 0; m_wrap = 0; m_seed = int'(seed);
      m_err  = (seed == 0);
      m_live = (seed != 0);
    end else if (f) begin
      nq  = model_next(m_q);
      m_q = nq;
      if (nq == m_seed) begin
        m_wrap = 1; m_period = (m_count + 1) % 16; m_count = 0;
      end else begin
        m_wrap = 0; m_count = (m_count + 1) % 16;
      end
    end else begin
      m_wrap = 0;
    end
    @(posedge clock);
    #1;
    chk("q",          q,          m_q);
    chk("serial_out", serial_out, m_q / 8);
    chk("out_valid",  out_valid,  m_live && enable);
    chk("wrap",       wrap,       m_wrap);
    chk("period",     period,     m_period);
    chk("error",      error,      m_err);
  endtask

  task automatic drive(input logic rst, input logic ld, input logic [3:0] sd,
                       input logic en, input logic rdy);
    reset = rst; load = ld; seed = sd; enable = en; out_ready = rdy;
  endtask

  initial begin
    int idx;
    int wraps;
    logic [3:0] held;
    logic [3:0] per_saved;

    m_q = 0; m_count = 0; m_period = 0; m_seed = 0;
    m_wrap = 0; m_err = 0; m_live = 0;

    // Reset held low with load and out_ready asserted: everything stays 0.
    drive(1'b0, 1'b1, 4'b0101, 1'b1, 1'b1);
    repeat (3) step();
    chk("rst_q", q, 0);
    // Release without load: still no valid output.
    drive(1'b1, 1'b0, 4'b0101, 1'b1, 1'b1);
    repeat (3) step();
    chk("idle_valid", out_valid, 0);

    // Full sequence from 0001 with continuous handshakes.
    drive(1'b1, 1'b1, 4'b0001, 1'b1, 1'b1);
    step();
    chk("seq_load", q, seq[0]);
    load  = 1'b0;
    wraps = 0;
    for (int i = 1; i <= 15; i++) begin
      step();
      chk("seq_q", q, seq[i]);
      if (wrap) wraps++;
      chk("seq_wrap", wrap, (i == 15));
    end
    chk("seq_wraps", wraps, 1);
    chk("seq_period", period, 15);
    step();
    chk("wrap_oneshot", wrap, 0);

    // Backpressure: toggle out_ready, q advances only on ready cycles.
    drive(1'b1, 1'b1, 4'b0001, 1'b1, 1'b0);
    step();
    load = 1'b0;
    idx  = 0;
    for (int i = 0; i < 12; i++) begin
      out_ready = ~out_ready;
      if (out_ready) idx++;
      step();
      chk("bp_q", q, seq[idx]);
    end
    // Drop enable for 3 cycles: no transfer, q frozen.
    held      = q;
    enable    = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en_hold_q", q, held);
      chk("en_hold_valid", out_valid, 0);
    end
    enable = 1'b1;

    // All-zero seed: error, locked at 0.
    drive(1'b1, 1'b1, 4'b0000, 1'b1, 1'b1);
    step();
    load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("zero_q", q, 0);
      chk("zero_err", error, 1);
    end
    // Recover with 1000; next step must give 0001.
    load = 1'b1; seed = 4'b1000;
    step();
    chk("recover_err", error, 0);
    load = 1'b0;
    step();
    chk("recover_step", q, 4'b0001);

    // Simultaneous load and fire at q=0111.
    drive(1'b1, 1'b1, 4'b0001, 1'b1, 1'b1);
    step();
    load = 1'b0;
    repeat (2) step();
    chk("pre_ld_q", q, 4'b0111);
    per_saved = period;
    load = 1'b1; seed = 4'b1010;
    step();
    chk("ldfire_q", q, 4'b1010);
    chk("ldfire_period", period, per_saved);
    load = 1'b0;
    repeat (15) step();     // count restarts: wrap lands after 15 steps
    chk("ldfire_back", q, 4'b1010);
    chk("ldfire_wrap", wrap, 1);

    // Mid-sequence reset at q=1101.
    drive(1'b1, 1'b1, 4'b0001, 1'b1, 1'b1);
    step();
    load = 1'b0;
    repeat (5) step();
    chk("pre_rst_q", q, 4'b1101);
    reset = 1'b0;
    step();
    chk("midrst_q", q, 0);
    chk("midrst_period", period, 0);
    chk("midrst_valid", out_valid, 0);
    drive(1'b1, 1'b1, 4'b0001, 1'b1, 1'b1);
    step();
    load = 1'b0;
    for (int i = 1; i < 5; i++) begin
      step();
      chk("restart_q", q, seq[i]);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      reset     = ($urandom_range(0, 99) != 0);
      load      = ($urandom_range(0, 24) == 0);
      seed      = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
      enable    = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_lfsr_seq
`default_nettype wire
